// File: rtl/i2c_mem_slave_if.sv
// I2C pin bundle between a bus master (or bench) and the memory target.
// scl_i/sda_i carry the resolved open-drain line levels; sda_oe is the
// target's pull-down request on SDA.
interface i2c_mem_slave_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe;

    modport master (
        output scl_i,
        output sda_i,
        input  sda_oe
    );

    modport slave (
        input  scl_i,
        input  sda_i,
        output sda_oe
    );
endinterface

// File: rtl/i2c_mem_slave.sv
// I2C target with a small byte-wide register file and an auto-incrementing
// pointer. Handles address+W, register byte, data writes, repeated START,
// address+R and multi-byte reads. All bus-facing outputs are registered;
// host_rdata is a combinational peek into the register file.
module i2c_mem_slave #(
    parameter int         ADDR_W     = 4,
    parameter logic [7:0] RESET_DATA = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        slave_addr,
    i2c_mem_slave_if.slave    bus,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic [7:0]        host_rdata,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_stb,
    output logic              busy
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        REG      = 4'd3,
        DATA_ACK = 4'd4,
        WRITE    = 4'd5,
        READ     = 4'd6,
        RD_ACK   = 4'd7,
        RD_NEXT  = 4'd8,
        IGNORE   = 4'd9
    } state_t;

    logic scl_meta_q, scl_s_q, scl_d_q;
    logic sda_meta_q, sda_s_q, sda_d_q;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [7:0]        tx_q, tx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, ptr_inc;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rd_stb_q, rd_stb_d;
    logic              busy_q, busy_d;
    logic              mem_we;
    logic [7:0]        mem_q [DEPTH];

    // Two-flop synchronisers plus a one-cycle history for edge detection;
    // reset to the idle-high bus level so no spurious START appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q <= 1'b1; scl_s_q <= 1'b1; scl_d_q <= 1'b1;
            sda_meta_q <= 1'b1; sda_s_q <= 1'b1; sda_d_q <= 1'b1;
        end else begin
            scl_meta_q <= bus.scl_i; scl_s_q <= scl_meta_q; scl_d_q <= scl_s_q;
            sda_meta_q <= bus.sda_i; sda_s_q <= sda_meta_q; sda_d_q <= sda_s_q;
        end
    end

    assign scl_rise  = !scl_d_q & scl_s_q;
    assign scl_fall  = scl_d_q & !scl_s_q;
    assign start_det = scl_d_q & scl_s_q & sda_d_q & !sda_s_q;
    assign stop_det  = scl_d_q & scl_s_q & !sda_d_q & sda_s_q;
    assign ptr_inc   = ptr_q + 1'b1;

    // Next-state and output decode; STOP beats START beats the state action.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        rd_stb_d  = 1'b0;
        mem_we    = 1'b0;
        if (stop_det) begin
            state_d   = IDLE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b0;
        end else if (start_det) begin
            state_d   = ADDR;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                ADDR, REG, WRITE: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        sr_d      = {sr_q[6:0], sda_s_q};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (state_q == ADDR) begin
                            if (sr_q[7:1] == slave_addr) begin
                                sda_oe_d = 1'b1;
                                state_d  = ADDR_ACK;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = IGNORE;
                            end
                        end else if (state_q == REG) begin
                            ptr_d    = sr_q[ADDR_W-1:0];
                            sda_oe_d = 1'b1;
                            state_d  = DATA_ACK;
                        end else begin
                            // Full byte received: commit it and advance.
                            mem_we    = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = sr_q;
                            ptr_d     = ptr_inc;
                            sda_oe_d  = 1'b1;
                            state_d   = DATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (sr_q[0]) begin
                            tx_d     = mem_q[ptr_q];
                            rd_stb_d = 1'b1;
                            sda_oe_d = ~mem_q[ptr_q][7];
                            state_d  = READ;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = REG;
                        end
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WRITE;
                    end
                end
                READ: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_ACK;
                        end else begin
                            tx_d     = {tx_q[6:0], 1'b0};
                            sda_oe_d = ~tx_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s_q) begin
                            ptr_d    = ptr_inc;
                            tx_d     = mem_q[ptr_inc];
                            rd_stb_d = 1'b1;
                            state_d  = RD_NEXT;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = IGNORE;
                        end
                    end
                end
                RD_NEXT: begin
                    if (scl_fall) begin
                        sda_oe_d  = ~tx_q[7];
                        bit_cnt_d = 4'd0;
                        state_d   = READ;
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                IDLE:    ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            sr_q      <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            rd_stb_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_stb_q  <= rd_stb_d;
            busy_q    <= busy_d;
        end
    end

    // Register file: every byte returns to RESET_DATA on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_DATA;
        end else if (mem_we) begin
            mem_q[ptr_q] <= sr_q;
        end
    end

    assign host_rdata = mem_q[host_raddr];
    assign bus.sda_oe = sda_oe_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign rd_stb     = rd_stb_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench for i2c_mem_slave: a bit-banged I2C master drives the
// open-drain bus, and each scenario task checks its own results inline.
module tb_i2c_mem_slave;
    localparam logic [7:0] RST_VAL  = 8'h3C;
    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_IGNR  = 4'd9;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] slave_addr = 7'h10;
    logic [3:0] host_raddr = 4'd0;
    logic [7:0] host_rdata;
    logic       wr_stb, rd_stb, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, rd_cnt = 0, oe_cnt = 0;
    logic [3:0] last_wr_addr = 4'd0;
    logic [7:0] last_wr_data = 8'd0;

    i2c_mem_slave_if bus ();
    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_mem_slave #(.ADDR_W(4), .RESET_DATA(RST_VAL)) dut (
        .clk(clk), .rst(rst), .slave_addr(slave_addr), .bus(bus),
        .host_raddr(host_raddr), .host_rdata(host_rdata),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_stb(rd_stb), .busy(busy)
    );

    always #5 clk = ~clk;

    // Running tallies of strobes and SDA pull-down cycles.
    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt++;
            last_wr_addr = wr_addr;
            last_wr_data = wr_data;
        end
        if (rd_stb) rd_cnt++;
        if (bus.sda_oe) oe_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation still running after 5 ms");
        $fatal(1, "timeout");
    end

    task automatic wait_q();
        repeat (8) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        b = bus.sda_i; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        host_raddr = a;
        #1;
        d = host_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wr_stb !== 1'b0 || rd_stb !== 1'b0) begin errors++; $display("FAIL reset_strobes: got wr=%b rd=%b expected 0 0", wr_stb, rd_stb); end
        checks++; if (dut.ptr_q !== 4'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        peek(4'd0, d);
        checks++; if (d !== RST_VAL) begin errors++; $display("FAIL reset_mem0: got %h expected %h", d, RST_VAL); end
        peek(4'd15, d);
        checks++; if (d !== RST_VAL) begin errors++; $display("FAIL reset_mem15: got %h expected %h", d, RST_VAL); end
    endtask

    task automatic test_write();
        logic [2:0] a;
        logic [7:0] d;
        int w0 = wr_cnt;
        slave_addr = 7'h10;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h06, a[1]);
        write_byte(8'hA5, a[0]);
        i2c_stop();
        checks++; if (a !== 3'b000) begin errors++; $display("FAIL write_acks: got %b expected 000", a); end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_stb_count: got %0d expected 1", wr_cnt - w0); end
        checks++; if (last_wr_addr !== 4'd6 || last_wr_data !== 8'hA5) begin errors++; $display("FAIL write_commit: got addr=%0d data=%h expected addr=6 data=a5", last_wr_addr, last_wr_data); end
        peek(4'd6, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL write_mem6: got %h expected a5", d); end
        checks++; if (dut.ptr_q !== 4'd7) begin errors++; $display("FAIL write_ptr: got %0d expected 7", dut.ptr_q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_master_read();
        logic [3:0] a;
        logic [7:0] d;
        int r0;
        i2c_start();
        write_byte(8'h20, a[3]);
        write_byte(8'h06, a[3]);
        write_byte(8'h5C, a[3]);
        i2c_stop();
        r0 = rd_cnt;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h06, a[1]);
        i2c_start();
        write_byte(8'h21, a[0]);
        read_byte(d, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (a[2:0] !== 3'b000) begin errors++; $display("FAIL read_acks: got %b expected 000", a[2:0]); end
        checks++; if (d !== 8'h5C) begin errors++; $display("FAIL read_data: got %h expected 5c", d); end
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_stb_count: got %0d expected 1", rd_cnt - r0); end
        checks++; if (dut.state_q !== ST_IGNR) begin errors++; $display("FAIL read_nack_state: got %0d expected %0d", dut.state_q, ST_IGNR); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL read_busy_before_stop: got %b expected 1", busy); end
        i2c_stop();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_stop: got %b expected 0", busy); end
    endtask

    task automatic test_mismatch();
        logic [2:0] a;
        logic [7:0] d;
        int w0 = wr_cnt;
        int o0 = oe_cnt;
        slave_addr = 7'h20;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h06, a[1]);
        write_byte(8'h77, a[0]);
        i2c_stop();
        slave_addr = 7'h10;
        checks++; if (a !== 3'b111) begin errors++; $display("FAIL mismatch_acks: got %b expected 111", a); end
        checks++; if (oe_cnt - o0 !== 0) begin errors++; $display("FAIL mismatch_sda_oe: got %0d pull-down cycles expected 0", oe_cnt - o0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL mismatch_wr_stb: got %0d expected 0", wr_cnt - w0); end
        peek(4'd6, d);
        checks++; if (d !== 8'h5C) begin errors++; $display("FAIL mismatch_mem6: got %h expected 5c", d); end
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        logic [7:0] d0, d1, d2, m0;
        int r0;
        i2c_start();
        write_byte(8'h20, a[7]);
        write_byte(8'h0F, a[6]);
        write_byte(8'hF1, a[5]);
        write_byte(8'h01, a[4]);
        write_byte(8'h12, a[3]);
        i2c_stop();
        r0 = rd_cnt;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h0F, a[1]);
        i2c_start();
        write_byte(8'h21, a[0]);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b0);
        read_byte(d2, 1'b1);
        i2c_stop();
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL wrap_acks: got %b expected 00000000", a); end
        checks++; if (d0 !== 8'hF1 || d1 !== 8'h01 || d2 !== 8'h12) begin errors++; $display("FAIL wrap_read_bytes: got %h %h %h expected f1 01 12", d0, d1, d2); end
        checks++; if (rd_cnt - r0 !== 3) begin errors++; $display("FAIL wrap_rd_stb_count: got %0d expected 3", rd_cnt - r0); end
        checks++; if (dut.ptr_q !== 4'd1) begin errors++; $display("FAIL wrap_ptr: got %0d expected 1", dut.ptr_q); end
        peek(4'd0, m0);
        checks++; if (m0 !== 8'h01) begin errors++; $display("FAIL wrap_mem0: got %h expected 01", m0); end
    endtask

    task automatic test_abort();
        logic [2:0] a;
        logic [7:0] d;
        int w0 = wr_cnt;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h03, a[1]);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_stop();
        repeat (4) @(negedge clk);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL abort_wr_stb: got %0d expected 0", wr_cnt - w0); end
        peek(4'd3, d);
        checks++; if (d !== RST_VAL) begin errors++; $display("FAIL abort_mem3: got %h expected %h", d, RST_VAL); end
        checks++; if (bus.sda_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle_outputs: got oe=%b busy=%b expected 0 0", bus.sda_oe, busy); end
        checks++; if (dut.state_q !== ST_IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dut.state_q, ST_IDLE); end
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h03, a[1]);
        write_byte(8'h99, a[0]);
        i2c_stop();
        peek(4'd3, d);
        checks++; if (a !== 3'b000 || wr_cnt - w0 !== 1 || d !== 8'h99) begin errors++; $display("FAIL abort_followup: got acks=%b wr=%0d mem3=%h expected 000 1 99", a, wr_cnt - w0, d); end
    endtask

    task automatic test_reset_mid_read();
        logic [2:0] a;
        logic [7:0] d;
        int o0, r0, w0;
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h04, a[1]);
        write_byte(8'h0F, a[0]);
        i2c_stop();
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h04, a[1]);
        i2c_start();
        write_byte(8'h21, a[0]);
        checks++; if (a !== 3'b000 || bus.sda_oe !== 1'b1) begin errors++; $display("FAIL rstread_setup: got acks=%b oe=%b expected 000 1", a, bus.sda_oe); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL rstread_sda_oe: got %b expected 0", bus.sda_oe); end
        checks++; if (dut.ptr_q !== 4'd0 || dut.state_q !== ST_IDLE) begin errors++; $display("FAIL rstread_ptr_state: got ptr=%0d state=%0d expected 0 0", dut.ptr_q, dut.state_q); end
        rst = 1'b0;
        peek(4'd4, d);
        checks++; if (d !== RST_VAL) begin errors++; $display("FAIL rstread_mem4: got %h expected %h", d, RST_VAL); end
        peek(4'd3, d);
        checks++; if (d !== RST_VAL) begin errors++; $display("FAIL rstread_mem3: got %h expected %h", d, RST_VAL); end
        o0 = oe_cnt; r0 = rd_cnt; w0 = wr_cnt;
        read_byte(d, 1'b1);
        i2c_stop();
        checks++; if (oe_cnt - o0 !== 0 || rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin errors++; $display("FAIL rstread_ignored: got oe=%0d rd=%0d wr=%0d expected 0 0 0", oe_cnt - o0, rd_cnt - r0, wr_cnt - w0); end
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL rstread_bus_released: got %h expected ff", d); end
        i2c_start();
        write_byte(8'h20, a[2]);
        write_byte(8'h02, a[1]);
        write_byte(8'h44, a[0]);
        i2c_stop();
        peek(4'd2, d);
        checks++; if (a !== 3'b000 || d !== 8'h44) begin errors++; $display("FAIL rstread_recovery: got acks=%b mem2=%h expected 000 44", a, d); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_master_read();
        test_mismatch();
        test_wrap();
        test_abort();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
